clkgen_sched: RTL and testbench
===============================

// Module: clkgen_sched
//
// PURPOSE
// - Synthesizable programmable clock/PWM generator controller. It sequences phase offset, high time and low time from a
//   runtime config, measured in cycles of the system clock `clk`.
// - Config changes made while running are held in a shadow register and applied only at a period boundary, so the output
//   never glitches. Sits between the config/CSR side and any block that needs a derived clock-enable or divided clock.
//
// PARAMETERS
// - CNT_W  16  width of period/ton/phase fields and the internal cycle counter
//
// PORTS
// - clk           in   1      system clock; all logic on posedge
// - rst           in   1      reset; synchronous, active-high
// - en            in   1      run request; level-sensitive
// - cfg_valid     in   1      config offered
// - cfg_ready     out  1      config can be accepted this cycle
// - cfg_period    in   CNT_W  period in clk cycles; legal range >=1
// - cfg_ton       in   CNT_W  high time in clk cycles
// - cfg_phase     in   CNT_W  start delay in clk cycles; used only on start from IDLE
// - cfg_err       out  1      1-cycle pulse: accepted config had period==0 (discarded)
// - clk_out       out  1      generated clock, registered
// - period_start  out  1      1-cycle pulse on the first cycle of every period
// - running       out  1      state != IDLE
//
// BEHAVIOUR
// - Reset: state=IDLE, clk_out=0, period_start=0, cfg_err=0, running=0, cfg_ready=1; active and shadow valid flags cleared.
// - Handshake: transfer occurs when cfg_valid&&cfg_ready; fields are sampled that cycle.
//   - cfg_ready = !shadow_vld.
//   - period==0: transfer completes, cfg_err pulses the next cycle, nothing is stored.
// - Config acceptance:
//   - In IDLE: a legal config loads the active registers directly.
//   - In PHASE/HIGH/LOW: a legal config loads the shadow register and sets shadow_vld.
// - States: IDLE, PHASE, HIGH, LOW. cnt counts cycles spent in the current state.
//   - IDLE  -> PHASE when en && act_vld && phase>0; -> HIGH when phase==0 (or LOW if ton==0).
//   - PHASE -> after phase cycles, enter HIGH (or LOW if ton==0).
//   - HIGH  -> after ton cycles, go to LOW. If ton>=period, stay high for the whole period and skip LOW.
//   - LOW   -> after period-ton cycles, the period ends.
// - Period end (last cycle of LOW, or of HIGH when LOW is skipped):
//   - If shadow_vld: copy shadow into active and clear shadow_vld. The new values govern the next period; the shadow phase is ignored.
//   - If !en: go to IDLE (graceful stop; the current period always completes).
//   - Otherwise start the next period.
// - Output timing:
//   - clk_out=1 exactly in HIGH cycles.
//   - period_start is high in the first cycle of each period, whether that cycle is HIGH or LOW.
// - Latency: en sampled high at edge t from IDLE gives the first period_start/clk_out at cycle t+1+phase.
// - Boundary cases:
//   - ton==0: output low for the full period.
//   - period==1 with ton>=1: clk_out held constant 1, period_start every cycle.
//   - en dropping during PHASE: abort to IDLE at the next edge with clk_out=0.
//   - en dropping and a config arriving in the same cycle: config is still accepted.
//   - rst mid-operation: immediate return to reset values; both the active and shadow configs are lost.
// - Width: cnt is CNT_W bits. period-ton is computed in CNT_W bits, guarded by the ton>=period check, so it never underflows.
//
// STRUCTURE
// - clkgen_pkg: state_t enum {IDLE, PHASE, HIGH, LOW}; cfg_t struct {period, ton, phase}; CNT_W_DEF=16.
// - Sub-module clkgen_shadow_reg: cfg_t holding register with vld flag, load, and consume-on-boundary.
// - Top: FSM, counter and output registers.
//
// TESTING
// 1. Reset sanity: rst for 3 cycles -> all outputs at reset values, cfg_ready=1.
// 2. Basic run: cfg {period=10, ton=5, phase=0}, en=1 -> 5 cycles high / 5 cycles low, period_start every 10 cycles.
// 3. Phase offset: cfg {period=4, ton=1, phase=7}, en at edge t -> first clk_out high at cycle t+8.
// 4. Live update: running {period=10, ton=5}, load {period=6, ton=2} mid-HIGH -> current period finishes 10 cycles,
//    then 2 high / 4 low. cfg_ready=0 until the boundary.
// 5. Edge configs:
//    - period=0 -> cfg_err pulse, no state change.
//    - ton=0 -> clk_out stays 0 with period_start still pulsing.
//    - ton=12, period=8 -> clk_out constant 1.
// 6. Stops:
//    - en drop mid-HIGH -> period completes, then IDLE with clk_out=0.
//    - rst mid-LOW -> IDLE on the next cycle.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared types for the programmable clock/PWM generator: FSM states and the
// period/high-time/phase configuration record.
package clkgen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] ton;
    logic [CNT_W_DEF-1:0] phase;
  } cfg_t;

  // A period opens in HIGH unless the high time is zero.
  function automatic state_t first_state(input logic ton_nonzero);
    return ton_nonzero ? HIGH : LOW;
  endfunction

endpackage

// File: rtl/clkgen_shadow_reg.sv
// Holding register for a config that arrives while the generator is running;
// it is consumed at the next period boundary (or promoted once idle).
module clkgen_shadow_reg
  import clkgen_pkg::*;
#(
  parameter type cfg_type = cfg_t
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  cfg_type load_cfg,
  input  logic    consume,
  output logic    vld,
  output cfg_type cfg
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (consume) begin
      vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cfg <= load_cfg;
    end
  end

endmodule

// File: rtl/clkgen_sched.sv
// Programmable clock/PWM generator: phase delay, then repeating HIGH/LOW
// periods, with glitch-free config updates applied only at period boundaries.
module clkgen_sched
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_start,
  output logic             running
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] ton;
    logic [CNT_W-1:0] phase;
  } cfg_w_t;

  cfg_w_t           cfg_in, act_cfg, shd_cfg, nxt_cfg;
  logic             act_vld, shd_vld;
  logic             xfer, xfer_ok, load_act, load_shd, consume;
  logic             period_end, ps_nxt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, low_len;

  assign cfg_in.period = cfg_period;
  assign cfg_in.ton    = cfg_ton;
  assign cfg_in.phase  = cfg_phase;

  assign cfg_ready = !shd_vld;
  assign xfer      = cfg_valid && cfg_ready;
  assign xfer_ok   = xfer && (cfg_period != '0);
  assign load_act  = xfer_ok && (state == IDLE);
  assign load_shd  = xfer_ok && (state != IDLE);
  assign running   = (state != IDLE);

  // Only meaningful when ton < period; the HIGH branch guards that case.
  assign low_len = act_cfg.period - act_cfg.ton;
  assign nxt_cfg = shd_vld ? shd_cfg : act_cfg;

  // A shadow left over after a stop is promoted while idle so cfg_ready recovers.
  assign consume = shd_vld && (period_end || (state == IDLE));

  clkgen_shadow_reg #(
    .cfg_type (cfg_w_t)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .load     (load_shd),
    .load_cfg (cfg_in),
    .consume  (consume),
    .vld      (shd_vld),
    .cfg      (shd_cfg)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    ps_nxt     = 1'b0;
    period_end = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!shd_vld && en && act_vld) begin
          if (act_cfg.phase != '0) begin
            state_nxt = PHASE;
          end else begin
            state_nxt = first_state(act_cfg.ton != '0);
            ps_nxt    = 1'b1;
          end
        end
      end
      PHASE: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == act_cfg.phase - CNT_W'(1)) begin
          state_nxt = first_state(act_cfg.ton != '0);
          cnt_nxt   = '0;
          ps_nxt    = 1'b1;
        end
      end
      HIGH: begin
        if (act_cfg.ton >= act_cfg.period) begin
          period_end = (cnt == act_cfg.period - CNT_W'(1));
        end else if (cnt == act_cfg.ton - CNT_W'(1)) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        period_end = (cnt == low_len - CNT_W'(1));
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // The next period opens with the shadow config if one is pending.
    if (period_end) begin
      cnt_nxt = '0;
      if (!en) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = first_state(nxt_cfg.ton != '0);
        ps_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      act_vld      <= 1'b0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      clk_out      <= (state_nxt == HIGH);
      period_start <= ps_nxt;
      cfg_err      <= xfer && (cfg_period == '0);
      if (load_act || consume) begin
        act_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_act) begin
      act_cfg <= cfg_in;
    end else if (consume) begin
      act_cfg <= shd_cfg;
    end
  end

endmodule

// File: tb/tb_clkgen_sched.sv
// Scoreboard bench for clkgen_sched: per-cycle expected outputs are queued as
// stimulus is applied and compared one entry per clock.
module tb_clkgen_sched;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_ton = '0;
  logic [CNT_W-1:0] cfg_phase = '0;
  logic             cfg_ready, cfg_err, clk_out, period_start, running;

  typedef struct packed {
    logic co;
    logic ps;
    logic run;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  clkgen_sched #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_ton      (cfg_ton),
    .cfg_phase    (cfg_phase),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .period_start (period_start),
    .running      (running)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic co, input logic ps, input logic run, input logic err);
    exp_t e;
    e.co  = co;
    e.ps  = ps;
    e.run = run;
    e.err = err;
    sb.push_back(e);
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_phase(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // First n cycles of one period of length p with high time t.
  task automatic push_period(input int p, input int t, input int n);
    for (int c = 0; c < n; c++) push((t >= p) || (c < t), (c == 0), 1'b1, 1'b0);
  endtask

  // Outputs are sampled 1 time unit after the edge; fields are {clk_out,period_start,running,cfg_err}.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("out{co,ps,run,err}@%0d", cyc),
               {28'b0, clk_out, period_start, running, cfg_err}, {28'b0, e});
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input int p, input int t, input int ph);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_ton    = CNT_W'(t);
    cfg_phase  = CNT_W'(ph);
  endtask

  task automatic load_idle(input int p, input int t, input int ph);
    offer(p, t, ph);
    push_idle(1);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset sanity
    rst = 1'b1;
    push_idle(3);
    steps(3);
    check_eq("rst_ready", cfg_ready, 1);
    rst = 1'b0;

    // Basic run 10/5, stop at a period boundary
    load_idle(10, 5, 0);
    en = 1'b1;
    repeat (3) push_period(10, 5, 10);
    steps(30);
    en = 1'b0;
    push_idle(2);
    steps(2);

    // Phase offset 7 before a 4/1 clock
    load_idle(4, 1, 7);
    en = 1'b1;
    push_phase(7);
    repeat (2) push_period(4, 1, 4);
    steps(15);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // Live update mid-HIGH: 10/5 finishes, then 6/2
    load_idle(10, 5, 0);
    en = 1'b1;
    push_period(10, 5, 10);
    repeat (2) push_period(6, 2, 6);
    steps(2);
    offer(6, 2, 0);
    steps(1);
    cfg_valid = 1'b0;
    check_eq("upd_ready_lo", cfg_ready, 0);
    steps(7);
    check_eq("upd_ready_hold", cfg_ready, 0);
    steps(1);
    check_eq("upd_ready_hi", cfg_ready, 1);
    steps(11);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // period==0 rejected; previous config (6/2) still governs
    offer(0, 3, 0);
    push(1'b0, 1'b0, 1'b0, 1'b1);
    steps(1);
    cfg_valid = 1'b0;
    push_idle(1);
    steps(1);
    check_eq("p0_ready", cfg_ready, 1);
    en = 1'b1;
    push_period(6, 2, 6);
    steps(6);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // ton==0: never high, period_start still pulses
    load_idle(5, 0, 0);
    en = 1'b1;
    repeat (2) push_period(5, 0, 5);
    steps(10);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // ton > period: constant high
    load_idle(8, 12, 0);
    en = 1'b1;
    repeat (2) push_period(8, 12, 8);
    steps(16);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // period==1, ton==1: constant high, period_start every cycle
    load_idle(1, 1, 0);
    en = 1'b1;
    repeat (4) push_period(1, 1, 1);
    steps(4);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // en drop mid-HIGH together with a new config: period completes, config kept
    load_idle(10, 5, 0);
    en = 1'b1;
    push_period(10, 5, 10);
    push_idle(1);
    steps(2);
    en = 1'b0;
    offer(4, 1, 0);
    steps(1);
    cfg_valid = 1'b0;
    check_eq("drop_ready_lo", cfg_ready, 0);
    steps(9);
    check_eq("drop_ready_hi", cfg_ready, 1);
    en = 1'b1;
    push_period(4, 1, 4);
    steps(4);
    en = 1'b0;
    push_idle(1);
    steps(1);

    // en drop during PHASE aborts immediately
    load_idle(4, 2, 3);
    en = 1'b1;
    push_phase(1);
    push_idle(2);
    steps(1);
    en = 1'b0;
    steps(2);

    // rst mid-LOW with a pending shadow: everything lost, stays idle with en high
    load_idle(10, 5, 0);
    en = 1'b1;
    push_period(10, 5, 7);
    push_idle(4);
    steps(6);
    offer(6, 2, 0);
    steps(1);
    cfg_valid = 1'b0;
    check_eq("rst_shadow_lo", cfg_ready, 0);
    rst = 1'b1;
    steps(1);
    check_eq("rst_shadow_clr", cfg_ready, 1);
    rst = 1'b0;
    steps(3);
    en = 1'b0;

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
